int_ctrl: RTL and testbench

Parametrised interrupt controller for BrainForge8, the successor of the fixed four-line interrupt unit. It accepts `NUM_SRC` request lines, each configurable as edge- or level-sensitive. It latches and masks requests, selects one by priority, and presents it to the core as `NEXT_ID`/`NEXT_ON` with an acknowledge / end-of-interrupt handshake. It sits between the external `INT` pins plus internal trigger sources (DMA, stack, software) and the core's interrupt entry logic.

---
 rtl/int_ctrl.sv | 255 +++++++++++++++++++++++++
 tb/tb_int_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_ctrl.sv
// int_ctrl -- parametrised interrupt controller for BrainForge8.
//
// Latches NUM_SRC request lines (edge- or level-sensitive per EDGE_MASK),
// plus synchronous internal triggers, masks them, selects one by priority
// and presents it to the core with an ACK / EOI handshake.
//
// Build option:
//   INT_CTRL_RR_EN  defined   -> rotating priority (pointer moves past each ACKed ID)
//                   undefined -> fixed priority, index 0 highest, no pointer logic
//
// Ports:
//   CLK      in   system clock, rising edge
//   RST      in   synchronous active-low reset
//   INT      in   raw request lines (asynchronous, 2-flop synchronised)
//   TRIG_ON  in   internal trigger strobe (synchronous)
//   TRIG_ID  in   source made pending by TRIG_ON; IDs >= NUM_SRC ignored
//   MASK_WE  in   mask write strobe
//   MASK_D   in   new mask value (1 = masked)
//   MASK_Q   out  current mask
//   PEND     out  pending vector before masking
//   NEXT_ON  out  interrupt presented to core
//   NEXT_ID  out  presented source ID, stable while NEXT_ON=1
//   ACK      in   core accepts presented interrupt
//   EOI      in   core finished servicing
//   IRQ      out  registered "controller not idle", one cycle behind state
module int_ctrl #(
  parameter int                 NUM_SRC   = 8,
  parameter int                 ID_W      = 3,
  parameter logic [NUM_SRC-1:0] EDGE_MASK = 8'h0F,
  parameter logic [NUM_SRC-1:0] MASK_RST  = {NUM_SRC{1'b1}}
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_SRC-1:0] INT,
  input  logic               TRIG_ON,
  input  logic [ID_W-1:0]    TRIG_ID,
  input  logic               MASK_WE,
  input  logic [NUM_SRC-1:0] MASK_D,
  output logic [NUM_SRC-1:0] MASK_Q,
  output logic [NUM_SRC-1:0] PEND,
  output logic               NEXT_ON,
  output logic [ID_W-1:0]    NEXT_ID,
  input  logic               ACK,
  input  logic               EOI,
  output logic               IRQ
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_PRESENT = 2'b01,
    ST_SERVICE = 2'b10
  } state_t;

  state_t               state_r;
  state_t               state_n;
  logic [NUM_SRC-1:0]   sync1_r;
  logic [NUM_SRC-1:0]   sync2_r;
  logic [NUM_SRC-1:0]   sync3_r;
  logic [NUM_SRC-1:0]   pend_r;
  logic [NUM_SRC-1:0]   held_r;
  logic [NUM_SRC-1:0]   mask_r;
  logic                 next_on_r;
  logic [ID_W-1:0]      next_id_r;
  logic                 irq_r;

  logic [NUM_SRC-1:0]   trig_hot_s;
  logic [NUM_SRC-1:0]   cur_hot_s;
  logic [NUM_SRC-1:0]   rise_s;
  logic [NUM_SRC-1:0]   clr_s;
  logic [NUM_SRC-1:0]   pend_n;
  logic [NUM_SRC-1:0]   held_n;
  logic [NUM_SRC-1:0]   elig_s;
  logic [NUM_SRC-1:0]   rot_s;
  logic                 ack_fire_s;
  logic                 scan_found_s;
  logic [ID_W-1:0]      scan_off_s;
  logic [ID_W-1:0]      win_id_s;

`ifdef INT_CTRL_RR_EN
  localparam logic [ID_W:0]   NUM_SRC_W  = (ID_W+1)'(NUM_SRC);
  // Modulo-2^ID_W image of NUM_SRC; wraps to 0 when NUM_SRC == 2^ID_W.
  localparam logic [ID_W-1:0] NUM_SRC_ID = ID_W'(NUM_SRC);
  logic [ID_W-1:0] ptr_r;
  logic [ID_W-1:0] ptr_n;
  logic [ID_W:0]   sum_s;
  logic [ID_W:0]   inc_s;
`endif

  // Two-flop synchroniser plus one history stage for rising-edge detection.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      sync1_r <= {NUM_SRC{1'b0}};
      sync2_r <= {NUM_SRC{1'b0}};
      sync3_r <= {NUM_SRC{1'b0}};
    end else begin
      sync1_r <= INT;
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
    end
  end

  assign ack_fire_s = (state_r == ST_PRESENT) && ACK;
  assign rise_s     = sync2_r & ~sync3_r;
  assign clr_s      = ack_fire_s ? cur_hot_s : {NUM_SRC{1'b0}};
  assign elig_s     = pend_r & ~mask_r;

  // One-hot decodes of the trigger target and the presented source.
  always_comb begin
    trig_hot_s = {NUM_SRC{1'b0}};
    cur_hot_s  = {NUM_SRC{1'b0}};
    for (int i = 0; i < NUM_SRC; i++) begin
      trig_hot_s[i] = TRIG_ON && (TRIG_ID == ID_W'(i));
      cur_hot_s[i]  = (next_id_r == ID_W'(i));
    end
  end

  // Next pending vector. Sets are OR-ed after the clear so a coincident set wins.
  // held_n keeps a trigger-set level bit alive until it is acknowledged.
  always_comb begin
    held_n = (trig_hot_s & ~EDGE_MASK) | (held_r & ~clr_s);
    pend_n = (EDGE_MASK & (rise_s | trig_hot_s | (pend_r & ~clr_s)))
           | (~EDGE_MASK & (sync2_r | held_n));
  end

  // Rotate the eligible vector so that bit 0 is the highest-priority slot.
  always_comb begin
`ifdef INT_CTRL_RR_EN
    rot_s = (elig_s >> ptr_r) | (elig_s << (NUM_SRC_W - {1'b0, ptr_r}));
`else
    rot_s = elig_s;
`endif
  end

  // Lowest set offset in the rotated vector; scanning downwards leaves the lowest.
  always_comb begin
    scan_found_s = 1'b0;
    scan_off_s   = {ID_W{1'b0}};
    for (int off = NUM_SRC - 1; off >= 0; off--) begin
      if (rot_s[off]) begin
        scan_found_s = 1'b1;
        scan_off_s   = ID_W'(off);
      end else begin
        // nothing eligible at this offset; keep the current candidate
      end
    end
  end

  // Map the winning offset back to a source ID.
  always_comb begin
`ifdef INT_CTRL_RR_EN
    sum_s = {1'b0, ptr_r} + {1'b0, scan_off_s};
    if (sum_s >= NUM_SRC_W) begin
      win_id_s = ptr_r + scan_off_s - NUM_SRC_ID;
    end else begin
      win_id_s = ptr_r + scan_off_s;
    end
`else
    win_id_s = scan_off_s;
`endif
  end

`ifdef INT_CTRL_RR_EN
  // Next pointer: one past the acknowledged ID, wrapping at NUM_SRC.
  always_comb begin
    inc_s = {1'b0, next_id_r} + {{ID_W{1'b0}}, 1'b1};
    if (!ack_fire_s) begin
      ptr_n = ptr_r;
    end else if (inc_s >= NUM_SRC_W) begin
      ptr_n = {ID_W{1'b0}};
    end else begin
      ptr_n = inc_s[ID_W-1:0];
    end
  end

  // Rotating-priority pointer register.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      ptr_r <= {ID_W{1'b0}};
    end else begin
      ptr_r <= ptr_n;
    end
  end
`endif

  // Handshake state register.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state logic; ACK takes precedence over a simultaneous loss of eligibility.
  always_comb begin
    state_n = state_r;
    case (state_r)
      ST_IDLE: begin
        if (scan_found_s) begin
          state_n = ST_PRESENT;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_PRESENT: begin
        if (ACK) begin
          state_n = ST_SERVICE;
        end else if (!(|(elig_s & cur_hot_s))) begin
          state_n = ST_IDLE;
        end else begin
          state_n = ST_PRESENT;
        end
      end
      ST_SERVICE: begin
        if (EOI) begin
          state_n = ST_IDLE;
        end else begin
          state_n = ST_SERVICE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Pending, mask and registered core-facing outputs.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      pend_r    <= {NUM_SRC{1'b0}};
      held_r    <= {NUM_SRC{1'b0}};
      mask_r    <= MASK_RST;
      next_on_r <= 1'b0;
      next_id_r <= {ID_W{1'b0}};
      irq_r     <= 1'b0;
    end else begin
      pend_r    <= pend_n;
      held_r    <= held_n;
      if (MASK_WE) begin
        mask_r <= MASK_D;
      end
      next_on_r <= (state_n == ST_PRESENT);
      // The ID is captured only on entry to PRESENT so it stays stable while shown.
      if ((state_r == ST_IDLE) && (state_n == ST_PRESENT)) begin
        next_id_r <= win_id_s;
      end
      irq_r     <= (state_r != ST_IDLE);
    end
  end

  assign MASK_Q  = mask_r;
  assign PEND    = pend_r;
  assign NEXT_ON = next_on_r;
  assign NEXT_ID = next_id_r;
  assign IRQ     = irq_r;

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: directed scenarios with constant
// expectations plus a randomized run checked cycle by cycle against a
// behavioural model of the controller's rules.
module tb_int_ctrl;
  localparam int N  = 8;
  localparam int IW = 3;
  localparam logic [N-1:0] EDGE = 8'h0F;
  localparam logic [N-1:0] MRST = 8'h00;
  localparam int M_IDLE = 0, M_PRESENT = 1, M_SERVICE = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  int_lines = '0;
  logic          trig_on = 1'b0;
  logic [IW-1:0] trig_id = '0;
  logic          mask_we = 1'b0;
  logic [N-1:0]  mask_d = '0;
  logic          ack = 1'b0;
  logic          eoi = 1'b0;
  logic [N-1:0]  mask_q, pend;
  logic          next_on, irq;
  logic [IW-1:0] next_id;

  int tests_run = 0;
  int tests_failed = 0;

  // reference model state
  logic [N-1:0] m_pend, m_held, m_mask, m_s0, m_s1, m_s2;
  int           m_mode, m_pid, m_ptr;
  logic         m_irq;

  always #5 clk = ~clk;

  int_ctrl #(.NUM_SRC(N), .ID_W(IW), .EDGE_MASK(EDGE), .MASK_RST(MRST)) dut (
    .CLK(clk), .RST(rst), .INT(int_lines), .TRIG_ON(trig_on), .TRIG_ID(trig_id),
    .MASK_WE(mask_we), .MASK_D(mask_d), .MASK_Q(mask_q), .PEND(pend),
    .NEXT_ON(next_on), .NEXT_ID(next_id), .ACK(ack), .EOI(eoi), .IRQ(irq)
  );

  // first eligible source searching upward from start, wrapping
  function automatic int pick(input logic [N-1:0] v, input int start);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (start + k) % N;
      if (v[idx]) return idx;
    end
    return 0;
  endfunction

  // apply one clock edge's worth of controller rules to the model
  task automatic model_edge();
    logic [N-1:0] elig, np, nh, edge_v;
    logic acked, trig, clr;
    int old_mode, start;
    edge_v = EDGE;
    if (!rst) begin
      m_pend = '0; m_held = '0; m_mask = MRST;
      m_s0 = '0; m_s1 = '0; m_s2 = '0;
      m_mode = M_IDLE; m_pid = 0; m_ptr = 0; m_irq = 1'b0;
    end else begin
      old_mode = m_mode;
      elig = m_pend & ~m_mask;
      acked = (m_mode == M_PRESENT) && ack;
      for (int i = 0; i < N; i++) begin
        trig = trig_on && (int'(trig_id) == i);
        clr  = acked && (m_pid == i);
        if (edge_v[i]) begin
          np[i] = (m_s1[i] && !m_s2[i]) || trig || (m_pend[i] && !clr);
          nh[i] = 1'b0;
        end else begin
          nh[i] = trig || (m_held[i] && !clr);
          np[i] = m_s1[i] || nh[i];
        end
      end
`ifdef INT_CTRL_RR_EN
      start = m_ptr;
`else
      start = 0;
`endif
      case (m_mode)
        M_IDLE:    if (elig != '0) begin m_mode = M_PRESENT; m_pid = pick(elig, start); end
        M_PRESENT: if (acked) begin m_mode = M_SERVICE; m_ptr = (m_pid + 1) % N; end
                   else if (!elig[m_pid]) m_mode = M_IDLE;
        M_SERVICE: if (eoi) m_mode = M_IDLE;
        default:   m_mode = M_IDLE;
      endcase
      m_irq = (old_mode != M_IDLE);
      if (mask_we) m_mask = mask_d;
      m_pend = np;
      m_held = nh;
      m_s2 = m_s1; m_s1 = m_s0; m_s0 = int_lines;
    end
  endtask

  // one clock: update model with the inputs the DUT will sample, then sample #1 later
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b0; int_lines = '0; trig_on = 1'b0; trig_id = '0;
    mask_we = 1'b0; mask_d = '0; ack = 1'b0; eoi = 1'b0;
    step_n(2);
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0; int_lines = 8'hFF; trig_on = 1'b1; trig_id = 3'd3; mask_we = 1'b1; mask_d = 8'hFF; ack = 1'b1;
    step_n(3);
    tests_run++; if (pend !== 8'h00) begin tests_failed++; $display("FAIL reset_pend: got %h want %h", pend, 8'h00); end
    tests_run++; if (mask_q !== MRST) begin tests_failed++; $display("FAIL reset_mask: got %h want %h", mask_q, MRST); end
    tests_run++; if (next_on !== 1'b0) begin tests_failed++; $display("FAIL reset_next_on: got %b want 0", next_on); end
    tests_run++; if (next_id !== 3'd0) begin tests_failed++; $display("FAIL reset_next_id: got %0d want 0", next_id); end
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL reset_irq: got %b want 0", irq); end
    do_reset();
  endtask

  task automatic test_edge_latency();
    do_reset();
    int_lines = 8'h04;
    step_n(2);
    tests_run++; if (pend !== 8'h00) begin tests_failed++; $display("FAIL edge_pend_early: got %h want 00", pend); end
    step();
    tests_run++; if (pend !== 8'h04) begin tests_failed++; $display("FAIL edge_pend_k2: got %h want 04", pend); end
    tests_run++; if (next_on !== 1'b0) begin tests_failed++; $display("FAIL edge_next_on_k2: got %b want 0", next_on); end
    step();
    tests_run++; if (next_on !== 1'b1 || next_id !== 3'd2) begin tests_failed++; $display("FAIL edge_present_k3: got on=%b id=%0d want on=1 id=2", next_on, next_id); end
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL edge_irq_lag: got %b want 0", irq); end
    step();
    tests_run++; if (irq !== 1'b1) begin tests_failed++; $display("FAIL edge_irq_set: got %b want 1", irq); end
    ack = 1'b1; step(); ack = 1'b0;
    tests_run++; if (next_on !== 1'b0 || pend !== 8'h00) begin tests_failed++; $display("FAIL edge_ack: got on=%b pend=%h want on=0 pend=00", next_on, pend); end
    step_n(2);
    tests_run++; if (next_on !== 1'b0 || irq !== 1'b1) begin tests_failed++; $display("FAIL edge_service_hold: got on=%b irq=%b want on=0 irq=1", next_on, irq); end
    eoi = 1'b1; step(); eoi = 1'b0;
    tests_run++; if (irq !== 1'b1) begin tests_failed++; $display("FAIL edge_eoi_irq_lag: got %b want 1", irq); end
    step();
    tests_run++; if (irq !== 1'b0 || next_on !== 1'b0) begin tests_failed++; $display("FAIL edge_idle: got irq=%b on=%b want 0 0", irq, next_on); end
  endtask

  task automatic test_priority();
    int exp_id;
    do_reset();
    int_lines = 8'h22;
    step_n(4);
    tests_run++; if (next_on !== 1'b1 || next_id !== 3'd1) begin tests_failed++; $display("FAIL prio_first: got on=%b id=%0d want on=1 id=1", next_on, next_id); end
    ack = 1'b1; step(); ack = 1'b0;
    tests_run++; if (pend !== 8'h20) begin tests_failed++; $display("FAIL prio_pend_after_ack: got %h want 20", pend); end
    eoi = 1'b1; step(); eoi = 1'b0;
    tests_run++; if (next_on !== 1'b0) begin tests_failed++; $display("FAIL prio_eoi_cycle: got %b want 0", next_on); end
    step();
    tests_run++; if (next_on !== 1'b1 || next_id !== 3'd5) begin tests_failed++; $display("FAIL prio_second: got on=%b id=%0d want on=1 id=5", next_on, next_id); end
    ack = 1'b1; int_lines = '0; step(); ack = 1'b0;
    step_n(3);
    eoi = 1'b1; step(); eoi = 1'b0;
    step();
    tests_run++; if (next_on !== 1'b0 || pend !== 8'h00) begin tests_failed++; $display("FAIL prio_drained: got on=%b pend=%h want 0 00", next_on, pend); end
    // acknowledge ID 1 alone, then raise 1 and 5 together
    do_reset();
    int_lines = 8'h02;
    step_n(4);
    ack = 1'b1; int_lines = '0; step(); ack = 1'b0;
    eoi = 1'b1; step(); eoi = 1'b0;
    int_lines = 8'h22;
    step_n(4);
`ifdef INT_CTRL_RR_EN
    exp_id = 5;
`else
    exp_id = 1;
`endif
    tests_run++; if (next_on !== 1'b1 || next_id !== 3'(exp_id)) begin tests_failed++; $display("FAIL prio_rotation: got on=%b id=%0d want on=1 id=%0d", next_on, next_id, exp_id); end
  endtask

  task automatic test_level_drop();
    do_reset();
    int_lines = 8'h40;
    step_n(4);
    tests_run++; if (next_on !== 1'b1 || next_id !== 3'd6) begin tests_failed++; $display("FAIL level_present: got on=%b id=%0d want 1 6", next_on, next_id); end
    int_lines = 8'h00;
    step_n(3);
    tests_run++; if (next_on !== 1'b1 || pend !== 8'h00) begin tests_failed++; $display("FAIL level_drop_pend: got on=%b pend=%h want 1 00", next_on, pend); end
    step();
    tests_run++; if (next_on !== 1'b0) begin tests_failed++; $display("FAIL level_withdrawn: got %b want 0", next_on); end
    int_lines = 8'h40;
    step_n(4);
    tests_run++; if (next_on !== 1'b1 || next_id !== 3'd6) begin tests_failed++; $display("FAIL level_represent: got on=%b id=%0d want 1 6", next_on, next_id); end
  endtask

  task automatic test_trig_ack();
    do_reset();
    trig_on = 1'b1; trig_id = 3'd3; step(); trig_on = 1'b0;
    tests_run++; if (pend !== 8'h08 || next_on !== 1'b0) begin tests_failed++; $display("FAIL trig_pend: got pend=%h on=%b want 08 0", pend, next_on); end
    step();
    tests_run++; if (next_on !== 1'b1 || next_id !== 3'd3) begin tests_failed++; $display("FAIL trig_present: got on=%b id=%0d want 1 3", next_on, next_id); end
    ack = 1'b1; trig_on = 1'b1; trig_id = 3'd3; step(); ack = 1'b0; trig_on = 1'b0;
    tests_run++; if (next_on !== 1'b0 || pend !== 8'h08) begin tests_failed++; $display("FAIL trig_set_wins: got on=%b pend=%h want 0 08", next_on, pend); end
    eoi = 1'b1; step(); eoi = 1'b0;
    step();
    tests_run++; if (next_on !== 1'b1 || next_id !== 3'd3) begin tests_failed++; $display("FAIL trig_represent: got on=%b id=%0d want 1 3", next_on, next_id); end
    ack = 1'b1; step(); ack = 1'b0;
    tests_run++; if (pend !== 8'h00) begin tests_failed++; $display("FAIL trig_cleared: got %h want 00", pend); end
    eoi = 1'b1; step(); eoi = 1'b0;
    trig_on = 1'b1; trig_id = 3'd7; step(); trig_on = 1'b0;
    step_n(3);
    tests_run++; if (pend !== 8'h80 || next_on !== 1'b1 || next_id !== 3'd7) begin tests_failed++; $display("FAIL trig_level_hold: got pend=%h on=%b id=%0d want 80 1 7", pend, next_on, next_id); end
    ack = 1'b1; step(); ack = 1'b0;
    tests_run++; if (pend !== 8'h00 || next_on !== 1'b0) begin tests_failed++; $display("FAIL trig_level_ack: got pend=%h on=%b want 00 0", pend, next_on); end
  endtask

  task automatic test_mask();
    do_reset();
    mask_we = 1'b1; mask_d = 8'h01; step(); mask_we = 1'b0;
    tests_run++; if (mask_q !== 8'h01) begin tests_failed++; $display("FAIL mask_write: got %h want 01", mask_q); end
    trig_on = 1'b1; trig_id = 3'd0; step(); trig_on = 1'b0;
    step_n(3);
    tests_run++; if (next_on !== 1'b0 || pend !== 8'h01) begin tests_failed++; $display("FAIL mask_blocks: got on=%b pend=%h want 0 01", next_on, pend); end
    mask_we = 1'b1; mask_d = 8'h00; step(); mask_we = 1'b0;
    tests_run++; if (mask_q !== 8'h00 || next_on !== 1'b0) begin tests_failed++; $display("FAIL mask_clear: got mask=%h on=%b want 00 0", mask_q, next_on); end
    step();
    tests_run++; if (next_on !== 1'b1 || next_id !== 3'd0) begin tests_failed++; $display("FAIL mask_unmask_present: got on=%b id=%0d want 1 0", next_on, next_id); end
    mask_we = 1'b1; mask_d = 8'h01; step(); mask_we = 1'b0;
    step();
    tests_run++; if (next_on !== 1'b0 || pend !== 8'h01) begin tests_failed++; $display("FAIL mask_withdraw: got on=%b pend=%h want 0 01", next_on, pend); end
  endtask

  task automatic test_reset_service();
    do_reset();
    trig_on = 1'b1; trig_id = 3'd2; mask_we = 1'b1; mask_d = 8'hF0; step(); mask_we = 1'b0;
    trig_id = 3'd6; step(); trig_on = 1'b0;
    ack = 1'b1; step(); ack = 1'b0;
    tests_run++; if (irq !== 1'b1 || pend !== 8'h40 || next_id !== 3'd2) begin tests_failed++; $display("FAIL rst_svc_setup: got irq=%b pend=%h id=%0d want 1 40 2", irq, pend, next_id); end
    rst = 1'b0; step();
    tests_run++; if (pend !== 8'h00 || mask_q !== MRST || next_on !== 1'b0 || next_id !== 3'd0 || irq !== 1'b0) begin tests_failed++; $display("FAIL rst_svc_outputs: got pend=%h mask=%h on=%b id=%0d irq=%b", pend, mask_q, next_on, next_id, irq); end
    rst = 1'b1; eoi = 1'b1; step(); eoi = 1'b0;
    step();
    tests_run++; if (next_on !== 1'b0 || irq !== 1'b0 || pend !== 8'h00) begin tests_failed++; $display("FAIL rst_svc_eoi_ignored: got on=%b irq=%b pend=%h", next_on, irq, pend); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 399) != 0);
      if ($urandom_range(0, 5) == 0) int_lines = int_lines ^ (8'h01 << $urandom_range(0, N - 1));
      trig_on = ($urandom_range(0, 4) == 0);
      trig_id = 3'($urandom_range(0, 7));
      mask_we = ($urandom_range(0, 15) == 0);
      mask_d  = 8'($urandom & $urandom);
      ack     = ($urandom_range(0, 2) == 0);
      eoi     = ($urandom_range(0, 3) == 0);
      step();
      tests_run++; if (pend !== m_pend) begin tests_failed++; $display("FAIL rand_pend c=%0d: got %h want %h", c, pend, m_pend); end
      tests_run++; if (mask_q !== m_mask) begin tests_failed++; $display("FAIL rand_mask c=%0d: got %h want %h", c, mask_q, m_mask); end
      tests_run++; if (next_on !== (m_mode == M_PRESENT)) begin tests_failed++; $display("FAIL rand_next_on c=%0d: got %b want %b", c, next_on, m_mode == M_PRESENT); end
      tests_run++; if (next_id !== 3'(m_pid)) begin tests_failed++; $display("FAIL rand_next_id c=%0d: got %0d want %0d", c, next_id, m_pid); end
      tests_run++; if (irq !== m_irq) begin tests_failed++; $display("FAIL rand_irq c=%0d: got %b want %b", c, irq, m_irq); end
    end
    rst = 1'b1; ack = 1'b0; eoi = 1'b0; trig_on = 1'b0; mask_we = 1'b0;
  endtask

  initial begin
    test_reset();
    test_edge_latency();
    test_priority();
    test_level_drop();
    test_trig_ack();
    test_mask();
    test_reset_service();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
